// File: rtl/ccg_pkg.sv
// Shared types and helpers for the CCG truth-table extraction harness.
package ccg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DRAIN
  } tt_state_e;

  localparam int N_IN_DFLT  = 3;
  localparam int N_OUT_DFLT = 4;
  localparam int TT_W       = 2 ** N_IN_DFLT;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // A single-output CUT still needs a one-bit column index.
  function automatic int col_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/ccg_tt_buffer.sv
// Truth-table store: one TT_W-bit column per CUT output, written one bit
// position (vector index) at a time across all columns, read a column at a time.
module ccg_tt_buffer
  import ccg_pkg::*;
#(
  parameter int N_IN  = N_IN_DFLT,
  parameter int N_OUT = N_OUT_DFLT,
  parameter int COL_W = col_width(N_OUT_DFLT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [N_IN-1:0]      idx,
  input  logic [N_OUT-1:0]     din,
  input  logic [COL_W-1:0]     col,
  output logic [2**N_IN-1:0]   dout
);

  localparam int W = 2 ** N_IN;

  logic [N_OUT-1:0][W-1:0] cols;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_col
    logic [W-1:0] bits_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bits_reg <= '0;
      end else if (we) begin
        bits_reg[idx] <= din[gi];
      end
    end

    assign cols[gi] = bits_reg;
  end

  assign dout = cols[col];

endmodule

// File: rtl/ccg_tt_extractor.sv
// Sweeps every input vector through a combinational CUT, collects the responses
// into per-output truth-table columns and streams them over valid/ready.
module ccg_tt_extractor
  import ccg_pkg::*;
#(
  parameter int  N_IN   = N_IN_DFLT,
  parameter int  N_OUT  = N_OUT_DFLT,
  parameter int  SETTLE = 1,
  localparam int W      = 2 ** N_IN,
  localparam int COL_W  = col_width(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out,
  output logic             busy,
  output logic             tt_valid,
  input  logic             tt_ready,
  output logic [W-1:0]     tt_data,
  output logic [COL_W-1:0] tt_col,
  output logic             tt_last,
  output logic             done
);

  localparam logic [3:0]       SETTLE_MAX = 4'(SETTLE);
  localparam logic [N_IN-1:0]  IDX_MAX    = {N_IN{1'b1}};
  localparam logic [COL_W-1:0] COL_MAX    = COL_W'(N_OUT - 1);

  tt_state_e        state_reg,  state_next;
  logic [N_IN-1:0]  idx_reg,    idx_next;
  logic [COL_W-1:0] col_reg,    col_next;
  logic [3:0]       cnt_reg,    cnt_next;
  logic [N_IN-1:0]  cut_in_reg, cut_in_next;
  logic             buf_we;
  logic             done_hs;
  logic [W-1:0]     col_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      col_reg    <= '0;
      cnt_reg    <= '0;
      cut_in_reg <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      col_reg    <= col_next;
      cnt_reg    <= cnt_next;
      cut_in_reg <= cut_in_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    col_next    = col_reg;
    cnt_next    = cnt_reg;
    cut_in_next = cut_in_reg;
    buf_we      = 1'b0;
    done_hs     = 1'b0;

    case (state_reg)
      IDLE: begin
        cut_in_next = '0;
        if (start) begin
          idx_next   = '0;
          cnt_next   = '0;
          state_next = ccg_pkg::SETTLE;
        end
      end
      // Always at least one cycle here, so each vector spans SETTLE+2 cycles.
      ccg_pkg::SETTLE: begin
        if (cnt_reg == SETTLE_MAX) begin
          cnt_next   = '0;
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      SAMPLE: begin
        buf_we = 1'b1;
        if (idx_reg == IDX_MAX) begin
          col_next   = '0;
          state_next = DRAIN;
        end else begin
          idx_next    = idx_reg + 1'b1;
          cut_in_next = idx_reg + 1'b1;
          state_next  = ccg_pkg::SETTLE;
        end
      end
      DRAIN: begin
        if (tt_ready) begin
          if (col_reg == COL_MAX) begin
            done_hs     = 1'b1;
            cut_in_next = '0;
            state_next  = IDLE;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort overrides every transition, including the final handshake.
    if (abort) begin
      state_next  = IDLE;
      cut_in_next = '0;
      buf_we      = 1'b0;
      done_hs     = 1'b0;
    end
  end

  ccg_tt_buffer #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .COL_W (COL_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .idx   (idx_reg),
    .din   (cut_out),
    .col   (col_reg),
    .dout  (col_word)
  );

  assign cut_in   = cut_in_reg;
  assign busy     = (state_reg != IDLE);
  assign tt_valid = (state_reg == DRAIN);
  assign tt_data  = tt_valid ? col_word : '0;
  assign tt_col   = tt_valid ? col_reg : '0;
  assign tt_last  = tt_valid && (col_reg == COL_MAX);
  assign done     = done_hs;

endmodule

// File: tb/tb_ccg_tt_extractor.sv
// Directed bench for ccg_tt_extractor: three instances (SETTLE = 1, 0, 3) each
// driving a combinational CUT model; drained words are checked against a scoreboard.
module tb_ccg_tt_extractor;

  localparam int ND = 3;

  typedef struct packed {
    logic [1:0] col;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start    [ND];
  logic       abort    [ND];
  logic       tt_ready [ND];
  logic [2:0] cut_in   [ND];
  logic [3:0] cut_out  [ND];
  logic       busy     [ND];
  logic       tt_valid [ND];
  logic [7:0] tt_data  [ND];
  logic [1:0] tt_col   [ND];
  logic       tt_last  [ND];
  logic       done     [ND];

  int   checks = 0;
  int   errors = 0;
  int   done_cnt [ND];
  exp_t sbq [$];
  logic [7:0] exp_cols [4];

  always #5 clk = ~clk;

  // f1 = x0^x1, f2 = 0, f3 = x2&~x1, f4 = ~x2|(x0&x1); bit0 = f1
  function automatic logic [3:0] cut_model(input logic [2:0] x);
    return {~x[2] | (x[0] & x[1]), x[2] & ~x[1], 1'b0, x[0] ^ x[1]};
  endfunction

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    assign cut_out[gi] = cut_model(cut_in[gi]);

    ccg_tt_extractor #(
      .N_IN   (3),
      .N_OUT  (4),
      .SETTLE (settle_of(gi))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[gi]),
      .abort    (abort[gi]),
      .cut_in   (cut_in[gi]),
      .cut_out  (cut_out[gi]),
      .busy     (busy[gi]),
      .tt_valid (tt_valid[gi]),
      .tt_ready (tt_ready[gi]),
      .tt_data  (tt_data[gi]),
      .tt_col   (tt_col[gi]),
      .tt_last  (tt_last[gi]),
      .done     (done[gi])
    );
  end

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (done[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int d, output int n);
    n = 0;
    while (tt_valid[d] !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  // Full sweep on instance d; optional 5-cycle stall per word; optional start held high.
  task automatic run_sweep(input int d, input bit stall, input bit hold);
    int         s, n, t1, t2, dc0;
    logic [2:0] prev;
    exp_t       e;
    s   = settle_of(d);
    dc0 = done_cnt[d];
    for (int k = 0; k < 4; k++) sbq.push_back('{col: 2'(k), data: exp_cols[k], last: (k == 3)});
    tt_ready[d] = 1'b1;
    start[d]    = 1'b1;
    tick();
    if (!hold) start[d] = 1'b0;
    n = 0; t1 = -1; t2 = -100; prev = cut_in[d];
    while (tt_valid[d] !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (cut_in[d] !== prev) begin
        if (cut_in[d] === 3'd1) t1 = n;
        if (cut_in[d] === 3'd2) t2 = n;
        prev = cut_in[d];
      end
    end
    chk($sformatf("sweep_len_d%0d", d), n, 8 * (s + 2));
    chk($sformatf("step_interval_d%0d", d), t2 - t1, s + 2);
    chk($sformatf("cut_in_held_d%0d", d), 32'(cut_in[d]), 7);
    e = '0;
    for (int w = 0; w < 4; w++) begin
      if (sbq.size() > 0) e = sbq.pop_front();
      if (stall) begin
        tt_ready[d] = 1'b0;
        for (int c = 0; c < 5; c++) begin
          #1;
          chk($sformatf("stall_valid_d%0d_w%0d", d, w), 32'(tt_valid[d]), 1);
          chk($sformatf("stall_data_d%0d_w%0d", d, w), 32'(tt_data[d]), 32'(e.data));
          chk($sformatf("stall_col_d%0d_w%0d", d, w), 32'(tt_col[d]), 32'(e.col));
          tick();
        end
        tt_ready[d] = 1'b1;
      end
      #1;
      chk($sformatf("data_d%0d_w%0d", d, w), 32'(tt_data[d]), 32'(e.data));
      chk($sformatf("col_d%0d_w%0d", d, w), 32'(tt_col[d]), 32'(e.col));
      chk($sformatf("last_d%0d_w%0d", d, w), 32'(tt_last[d]), 32'(e.last));
      chk($sformatf("done_d%0d_w%0d", d, w), 32'(done[d]), 32'(e.last));
      tick();
    end
    chk($sformatf("valid_drop_d%0d", d), 32'(tt_valid[d]), 0);
    chk($sformatf("idle_busy_d%0d", d), 32'(busy[d]), 0);
    chk($sformatf("idle_cut_in_d%0d", d), 32'(cut_in[d]), 0);
    chk($sformatf("done_count_d%0d", d), done_cnt[d], dc0 + 1);
    if (hold) begin
      tick();
      chk("hold_restart_busy", 32'(busy[d]), 1);
      start[d] = 1'b0;
      abort[d] = 1'b1;
      tick();
      abort[d] = 1'b0;
      chk("hold_cleanup_busy", 32'(busy[d]), 0);
    end
  endtask

  initial begin
    int n;
    int dc;
    exp_cols = '{8'h66, 8'h00, 8'h30, 8'h8F};
    for (int d = 0; d < ND; d++) begin
      start[d]    = 1'b0;
      abort[d]    = 1'b0;
      tt_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_outputs_d%0d", d),
          {busy[d], tt_valid[d], tt_last[d], done[d], cut_in[d], tt_col[d], tt_data[d]}, 0);
    end
    rst_n = 1'b1;
    tick();

    // Basic sweeps at SETTLE = 1, 0, 3, then backpressure at SETTLE = 1.
    run_sweep(0, 1'b0, 1'b0);
    run_sweep(1, 1'b0, 1'b0);
    run_sweep(2, 1'b0, 1'b0);
    run_sweep(0, 1'b1, 1'b0);

    // start and abort together in IDLE: stay idle.
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("start_abort_idle", 32'(busy[0]), 0);

    // Abort at idx = 4.
    dc = done_cnt[0];
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (cut_in[0] !== 3'd4 && n < 400) begin
      tick();
      n++;
    end
    chk("abort_reach_idx4", 32'(cut_in[0]), 4);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("abort_sweep_busy", 32'(busy[0]), 0);
    chk("abort_sweep_valid", 32'(tt_valid[0]), 0);
    chk("abort_sweep_cut_in", 32'(cut_in[0]), 0);
    repeat (3) tick();
    chk("abort_sweep_stays_idle", 32'(busy[0]), 0);
    chk("abort_sweep_no_done", done_cnt[0], dc);

    // Abort mid-drain after column 1 is accepted.
    start[0] = 1'b1;
    tt_ready[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_valid(0, n);
    chk("abort_drain_reach", 32'(tt_valid[0]), 1);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("abort_drain_word%0d", w), 32'(tt_data[0]), 32'(exp_cols[w]));
      tick();
    end
    chk("abort_drain_col2", 32'(tt_col[0]), 2);
    abort[0] = 1'b1;
    #1;
    chk("abort_drain_done_low", 32'(done[0]), 0);
    tick();
    abort[0] = 1'b0;
    chk("abort_drain_busy", 32'(busy[0]), 0);
    chk("abort_drain_valid", 32'(tt_valid[0]), 0);
    chk("abort_drain_cut_in", 32'(cut_in[0]), 0);
    chk("abort_drain_no_done", done_cnt[0], dc);
    run_sweep(0, 1'b0, 1'b0);

    // Asynchronous reset between clock edges mid-sweep.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy[0]), 0);
    chk("async_rst_cut_in", 32'(cut_in[0]), 0);
    chk("async_rst_stream", {tt_valid[0], tt_last[0], done[0], tt_col[0], tt_data[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_sweep(0, 1'b0, 1'b0);

    // start held high for the whole run: one sweep, restart only after IDLE.
    run_sweep(0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
